beat_packer: RTL and testbench
==============================

# beat_packer

Narrow-to-wide stream packer placed directly downstream of a narrow `fifo` instance. It consumes `IN_WIDTH`-bit beats over a valid/ready handshake and assembles `RATIO` beats into one wide word, lowest slot first. A packet-end marker (`i_last`) flushes a partially filled word early, and a per-slot mask identifies which slots hold data. The output is registered, so the block also serves as a pipeline stage between the FIFO and the wide consumer.

## Interface
- `IN_WIDTH`, default 8: width of one input beat in bits; must be ≥ 1.
- `RATIO`, default 4: number of beats per output word; must be a power of 2 and ≥ 2, otherwise `$fatal` at elaboration.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `i_valid`  input  1  input beat valid.
- `i_ready`  output  1  block accepts the input beat this cycle.
- `i_data`  input  `IN_WIDTH`  input beat.
- `i_last`  input  1  beat is the final one of its packet; qualified by `i_valid`.
- `o_valid`  output  1  packed word available.
- `o_ready`  input  1  consumer accepts the word.
- `o_data`  output  `IN_WIDTH*RATIO`  packed word; slot k occupies bits `[k*IN_WIDTH +: IN_WIDTH]`.
- `o_mask`  output  `RATIO`  bit k set means slot k holds a valid beat.
- `o_last`  output  1  word ends a packet.

## Operation
- Internal state:
  - Slot counter `cnt`, `$clog2(RATIO)` bits.
  - Accumulator for slots 0..`RATIO`-2, with a matching mask.
  - Output register holding `o_data`, `o_mask`, `o_last` and `o_valid`.
- Input handshake:
  - `i_ready = !o_valid || o_ready`. This is a combinational path from `o_ready` and is required.
  - `i_ready` does not depend on `i_valid`, `i_data` or `i_last`.
- An input beat is accepted when `i_valid && i_ready`.
- Non-completing accept (`cnt != RATIO-1` and `!i_last`):
  - Write `i_data` into accumulator slot `cnt` and set mask bit `cnt`.
  - `cnt <= cnt + 1`.
  - The output register is unchanged, apart from draining if `o_ready` is high.
- Completing accept (`cnt == RATIO-1` or `i_last`):
  - Load the output register:
    - `o_data` = accumulator slots with `i_data` merged into slot `cnt`.
    - `o_mask` = accumulator mask with bit `cnt` set.
    - `o_last` = `i_last`.
    - `o_valid` = 1.
  - Unfilled slots in `o_data` are driven to zero.
  - Clear the accumulator data and mask to zero.
  - `cnt <= 0`.
- Output drain: `o_valid && o_ready` with no simultaneous completing accept sets `o_valid` to 0 and leaves the payload registers unchanged.
- Simultaneous drain and completing accept: the new word replaces the old one in the same edge and `o_valid` stays 1. No bubble.
- Output stability: while `o_valid && !o_ready`, `o_data`, `o_mask` and `o_last` hold stable.
- Consequence of the `i_ready` rule: while the output register is full and not draining, no beats are accepted, including non-completing ones.
- When `cnt == RATIO-1` and `i_last == 1`, the word completes with a full mask and `o_last` = 1.
- `cnt` wraps only via the completing rule and never exceeds `RATIO-1`.

## Timing
- Reset values: `o_valid` 0, `o_data` 0, `o_mask` 0, `o_last` 0, `cnt` 0, accumulator 0.
- `i_ready` is 1 immediately after reset, because `o_valid` is 0.
- Reset asserted mid-packet discards all partial beats and any pending output word. The next accepted beat lands in slot 0.
- Latency: the completing beat accepted at edge N gives `o_valid` = 1 in the cycle after edge N.
- Throughput with `o_ready` held high: one input beat per cycle sustained, and one output word every `RATIO` accepted beats (sooner on `i_last`).
- No combinational path from `i_valid`/`i_data` to any output.

## Test plan
- Full packing, `IN_WIDTH`=8, `RATIO`=4, `o_ready`=1:
  - Stimulus: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `i_last`=0.
  - Response: exactly one word, `o_data`=0x44332211, `o_mask`=4'b1111, `o_last`=0, `o_valid` high for one cycle, one cycle after the 0x44 accept.
- Early flush:
  - Stimulus: 0xAA, 0xBB, 0xCC with `i_last` on 0xCC.
  - Response: `o_data`=0x00CCBBAA, `o_mask`=4'b0111, `o_last`=1.
  - Follow-up: the next beat 0x5A (last) gives `o_data`=0x0000005A, `o_mask`=4'b0001.
- Backpressure:
  - Stimulus: complete a word, then hold `o_ready`=0 for 5 cycles while `i_valid`=1.
  - Response: `i_ready`=0 and the word stays stable throughout.
  - Release: on `o_ready`=1, `i_ready` rises in the same cycle and the packing of the stalled beats proceeds with no loss or duplication.
- Back-to-back words:
  - Stimulus: 8 beats 0x01..0x08 streamed with `o_ready`=1.
  - Response: word 0x04030201 and then word 0x08070605, four cycles apart, with no stall cycles on `i_ready`.
- Simultaneous drain and complete:
  - Stimulus: `o_ready` rises in the same cycle as the completing beat of the next word.
  - Response: `o_valid` stays 1 and `o_data` switches to the new word on the next edge.
- Reset mid-packet:
  - Stimulus: after 2 beats, pulse `rstn` low asynchronously, then send 4 fresh beats.
  - Response: all outputs return to 0, and the first post-reset word contains only the 4 fresh beats.

Source files
------------

// File: rtl/beat_packer.sv
// beat_packer: narrow-to-wide stream packer with a registered output stage.
// Collects RATIO beats of IN_WIDTH bits, lowest slot first, into one wide word.
// A beat with i_last set closes the word early. o_mask shows which slots hold data.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   i_valid/i_ready    input beat handshake (i_ready = !o_valid || o_ready)
//   i_data, i_last     input beat and end-of-packet marker
//   o_valid/o_ready    output word handshake
//   o_data             packed word, slot k at [k*IN_WIDTH +: IN_WIDTH]
//   o_mask             bit k set when slot k holds a beat
//   o_last             word ends a packet
module beat_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [IN_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]          o_mask,
  output logic                      o_last
);

  localparam int CW    = $clog2(RATIO);
  localparam int ACC_W = (RATIO - 1) * IN_WIDTH;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $fatal(1, "beat_packer: RATIO must be a power of 2 and >= 2");
  end
  if (IN_WIDTH < 1) begin : g_bad_width
    $fatal(1, "beat_packer: IN_WIDTH must be >= 1");
  end

  logic [CW-1:0]             cnt;
  logic [ACC_W-1:0]          acc;
  logic [RATIO-2:0]          acc_mask;
  logic                      accept;
  logic                      complete;
  logic [IN_WIDTH*RATIO-1:0] word;
  logic [RATIO-1:0]          word_mask;

  assign i_ready  = !o_valid || o_ready;
  assign accept   = i_valid && i_ready;
  assign complete = (cnt == CW'(RATIO - 1)) || i_last;

  // Word to load on a completing beat: accumulated slots plus the current
  // beat in slot cnt; slots above cnt stay zero.
  always_comb begin
    word = '0;
    word[ACC_W-1:0] = acc;
    word[int'(cnt) * IN_WIDTH +: IN_WIDTH] = i_data;
    word_mask = {1'b0, acc_mask};
    word_mask[cnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      acc      <= '0;
      acc_mask <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_mask   <= '0;
      o_last   <= 1'b0;
    end else if (accept && complete) begin
      // Also covers a simultaneous drain: the new word replaces the old one.
      o_data   <= word;
      o_mask   <= word_mask;
      o_last   <= i_last;
      o_valid  <= 1'b1;
      acc      <= '0;
      acc_mask <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        acc[int'(cnt) * IN_WIDTH +: IN_WIDTH] <= i_data;
        acc_mask[cnt] <= 1'b1;
        cnt <= cnt + CW'(1);
      end
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// Directed testbench for beat_packer with IN_WIDTH=8, RATIO=4.
module tb_beat_packer;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [3:0]  o_mask;
  logic        o_last;

  int checks = 0;
  int errors = 0;

  // {o_valid, o_last, o_mask, o_data}
  logic [37:0] obs;
  assign obs = {o_valid, o_last, o_mask, o_data};

  beat_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_mask  (o_mask),
    .o_last  (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Present one beat and advance past the next rising edge.
  task automatic send(input logic [7:0] d, input logic l);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; o_ready = 1'b0; idle();
    #12;
    checks++;
    if (obs !== 38'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required %h", obs, 38'h0);
    end
    checks++;
    if (i_ready !== 1'b1) begin
      errors++; $display("FAIL reset_i_ready: got %b required 1", i_ready);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_pack();
    o_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL full_no_early_word: got o_valid=%b required 0", o_valid);
    end
    send(8'h44, 1'b0);
    idle();
    checks++;
    if (obs !== {1'b1, 1'b0, 4'b1111, 32'h44332211}) begin
      errors++; $display("FAIL full_word: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'h44332211});
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL full_one_cycle: got o_valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_early_flush();
    o_ready = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'b0111, 32'h00CCBBAA}) begin
      errors++; $display("FAIL flush_word: got %h required %h", obs, {1'b1, 1'b1, 4'b0111, 32'h00CCBBAA});
    end
    send(8'h5A, 1'b1);
    idle();
    checks++;
    if (obs !== {1'b1, 1'b1, 4'b0001, 32'h0000005A}) begin
      errors++; $display("FAIL flush_single: got %h required %h", obs, {1'b1, 1'b1, 4'b0001, 32'h0000005A});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    o_ready = 1'b1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    o_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h10; i_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (i_ready !== 1'b0) begin
        errors++; $display("FAIL stall_i_ready[%0d]: got %b required 0", i, i_ready);
      end
      checks++;
      if (obs !== {1'b1, 1'b0, 4'b1111, 32'h04030201}) begin
        errors++; $display("FAIL stall_word[%0d]: got %h required %h", i, obs, {1'b1, 1'b0, 4'b1111, 32'h04030201});
      end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++; $display("FAIL release_i_ready: got %b required 1", i_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL release_drain: got o_valid=%b required 0", o_valid);
    end
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    idle();
    checks++;
    if (obs !== {1'b1, 1'b0, 4'b1111, 32'h40302010}) begin
      errors++; $display("FAIL release_word: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'h40302010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      i_valid = 1'b1; i_data = 8'(b); i_last = 1'b0;
      #1;
      checks++;
      if (i_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_i_ready[%0d]: got %b required 1", b, i_ready);
      end
      @(posedge clk); #1;
      if (b == 4) begin
        checks++;
        if (obs !== {1'b1, 1'b0, 4'b1111, 32'h04030201}) begin
          errors++; $display("FAIL b2b_word0: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'h04030201});
        end
      end else if (b == 8) begin
        checks++;
        if (obs !== {1'b1, 1'b0, 4'b1111, 32'h08070605}) begin
          errors++; $display("FAIL b2b_word1: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'h08070605});
        end
      end else begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_gap[%0d]: got o_valid=%b required 0", b, o_valid);
        end
      end
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_simul_drain();
    o_ready = 1'b1;
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b0);
    idle();
    o_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 4'b1111, 32'hE4E3E2E1}) begin
      errors++; $display("FAIL simul_hold: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'hE4E3E2E1});
    end
    o_ready = 1'b1;
    send(8'h77, 1'b1);
    idle();
    checks++;
    if (obs !== {1'b1, 1'b1, 4'b0001, 32'h00000077}) begin
      errors++; $display("FAIL simul_replace: got %h required %h", obs, {1'b1, 1'b1, 4'b0001, 32'h00000077});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b1;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    idle();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 38'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h required %h", obs, 38'h0);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_no_stale: got o_valid=%b required 0", o_valid);
    end
    send(8'hD4, 1'b0);
    idle();
    checks++;
    if (obs !== {1'b1, 1'b0, 4'b1111, 32'hD4D3D2D1}) begin
      errors++; $display("FAIL midreset_word: got %h required %h", obs, {1'b1, 1'b0, 4'b1111, 32'hD4D3D2D1});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_pack();
    test_early_flush();
    test_backpressure();
    test_back_to_back();
    test_simul_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
